// File: rtl/piece_bag_gen_pkg.sv
// Shared types and constants for the bag-rule piece generator.
// Also hosts a small popcount helper used for the bag_remaining output.
package piece_bag_gen_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } bag_state_e;

    localparam int          NUM_TETROMINOES = 7;
    localparam logic [15:0] DEFAULT_SEED    = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/piece_bag_gen_if.sv
// Consumer-facing bus of the piece generator: reseed/pop controls in,
// queue head, preview slots and bag occupancy out.
interface piece_bag_gen_if #(
    parameter int NUM_PIECES    = 7,
    parameter int PREVIEW_DEPTH = 3,
    parameter int LFSR_W        = 16
);
    localparam int PIECE_W = $clog2(NUM_PIECES);

    logic                               seed_load;
    logic [LFSR_W-1:0]                  seed_in;
    logic                               piece_pop;
    logic                               piece_valid;
    logic [PIECE_W-1:0]                 piece_out;
    logic [PIECE_W*PREVIEW_DEPTH-1:0]   preview_out;
    logic [3:0]                         bag_remaining;

    modport master (
        output seed_load, seed_in, piece_pop,
        input  piece_valid, piece_out, preview_out, bag_remaining
    );

    modport slave (
        input  seed_load, seed_in, piece_pop,
        output piece_valid, piece_out, preview_out, bag_remaining
    );

endinterface

// File: rtl/piece_bag_gen_lfsr.sv
// Free-running right-shifting Galois LFSR with synchronous reload.
// A zero reload value would lock the register, so it falls back to SEED.
module lfsr_galois #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = 16'hB400,
    parameter logic [W-1:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
        end else begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/piece_bag_gen.sv
// Bag-rule piece generator: draws each ID once per bag in LFSR order and
// keeps a shift-register queue holding the current piece plus the preview.
module piece_bag_gen
    import piece_bag_gen_pkg::*;
#(
    parameter int                NUM_PIECES    = 7,
    parameter int                PREVIEW_DEPTH = 3,
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS     = DEFAULT_TAPS_16,
    parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            reset,
    piece_bag_gen_if.slave  bus
);

    localparam int PIECE_W = $clog2(NUM_PIECES);
    localparam int QDEPTH  = PREVIEW_DEPTH + 1;
    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0]      QDEPTH_C  = CNT_W'(QDEPTH);
    localparam logic [NUM_PIECES-1:0] FULL_MASK = '1;

    logic [LFSR_W-1:0]     lfsr_state;
    logic                  unused_lfsr_bits;

    bag_state_e            state_q;
    logic                  valid_q;
    logic [NUM_PIECES-1:0] mask_q, mask_d;
    logic [3:0]            remaining_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PIECE_W-1:0]    queue_q [QDEPTH];
    logic [PIECE_W-1:0]    queue_d [QDEPTH];

    logic                  pop;
    logic                  push;
    logic [PIECE_W-1:0]    cand;
    logic [PIECE_W-1:0]    drawn;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.seed_load),
        .load_val (bus.seed_in),
        .state    (lfsr_state)
    );

    // Only the low PIECE_W bits pick the starting candidate.
    assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:PIECE_W];

    // First ID still in the bag at or above cand, wrapping past the top ID.
    function automatic logic [PIECE_W-1:0] pick_from_bag(
        input logic [NUM_PIECES-1:0] mask,
        input logic [PIECE_W-1:0]    start
    );
        logic [PIECE_W-1:0] sel;
        logic               found;
        int                 idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            idx = (int'(start) + k) % NUM_PIECES;
            if (!found && mask[idx]) begin
                sel   = PIECE_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        pop     = bus.piece_pop & valid_q;
        push    = (count_q < QDEPTH_C) | pop;
        cand    = PIECE_W'(int'(lfsr_state[PIECE_W-1:0]) % NUM_PIECES);
        drawn   = pick_from_bag(mask_q, cand);
        mask_d  = mask_q;
        count_d = count_q;
        queue_d = queue_q;

        if (push) begin
            mask_d[drawn] = 1'b0;
            if (mask_d == '0) begin
                mask_d = FULL_MASK;
            end
        end

        // A pop always comes with a refill, so the queue just slides.
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                queue_d[i] = queue_q[i+1];
            end
            queue_d[QDEPTH-1] = drawn;
        end else if (push) begin
            queue_d[count_q] = drawn;
            count_d          = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            valid_q     <= 1'b0;
            mask_q      <= FULL_MASK;
            remaining_q <= 4'(NUM_PIECES);
            count_q     <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else if (bus.seed_load) begin
            state_q     <= ST_FILL;
            valid_q     <= 1'b0;
            mask_q      <= FULL_MASK;
            remaining_q <= 4'(NUM_PIECES);
            count_q     <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            mask_q      <= mask_d;
            remaining_q <= popcount8(8'(mask_d));
            count_q     <= count_d;
            queue_q     <= queue_d;
            case (state_q)
                ST_FILL: begin
                    if (count_d == QDEPTH_C) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    valid_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_FILL;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.piece_valid   = valid_q;
    assign bus.piece_out     = queue_q[0];
    assign bus.bag_remaining = remaining_q;

    generate
        for (genvar gi = 0; gi < PREVIEW_DEPTH; gi++) begin : g_preview
            assign bus.preview_out[gi*PIECE_W +: PIECE_W] = queue_q[gi+1];
        end
    endgenerate

endmodule
